// File: rtl/i2s_frame_tx.sv
// Parametrised I2S / left-justified frame serialiser: one multi-slot frame per
// accepted sample word, gapless back-to-back frames, sticky underrun flag.
module i2s_frame_tx #(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 16,
    parameter int NUM_CH   = 2
) (
    input  logic                         bclk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         fmt_i2s,
    input  logic [NUM_CH*SAMPLE_W-1:0]   s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic                         lrclk,
    output logic                         sd,
    output logic [$clog2(NUM_CH)-1:0]    slot_idx,
    output logic                         frame_start,
    output logic                         underrun,
    output logic                         busy
);

    localparam int BIT_W   = $clog2(SLOT_W);
    localparam int SI_W    = $clog2(NUM_CH);
    localparam int FRAME_W = NUM_CH * SAMPLE_W;

    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SLOT_W - 1);
    localparam logic [SI_W-1:0]  SLOT_LAST = SI_W'(NUM_CH - 1);
    localparam logic [SI_W-1:0]  SLOT_HALF = SI_W'(NUM_CH / 2);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state;
    logic [BIT_W-1:0]     bit_cnt;
    logic [SI_W-1:0]      slot_cnt;
    logic [FRAME_W-1:0]   frame_q;
    logic                 fmt_q;
    logic                 first_q;
    logic                 dly_q;

    logic                 at_last;
    logic                 load_new;
    logic [BIT_W-1:0]     nxt_bit;
    logic [SI_W-1:0]      nxt_slot;
    logic [FRAME_W-1:0]   emit_frame;
    logic                 emit_fmt;
    logic                 lj_nxt;

    // Left-justified bit for a slot position: sample MSB first, then zero pad.
    function automatic logic slot_bit(input logic [FRAME_W-1:0] f,
                                      input int slot, input int b);
        logic [FRAME_W-1:0] sh;
        if (b >= SAMPLE_W) return 1'b0;
        sh = f >> (slot * SAMPLE_W + SAMPLE_W - 1 - b);
        return sh[0];
    endfunction

    always_comb begin
        at_last  = (bit_cnt == BIT_LAST) && (slot_cnt == SLOT_LAST);
        nxt_bit  = bit_cnt + 1'b1;
        nxt_slot = slot_cnt;
        if (bit_cnt == BIT_LAST) begin
            nxt_bit  = '0;
            nxt_slot = at_last ? '0 : slot_cnt + 1'b1;
        end
        // first_q: data latched from IDLE, bit 0 of slot 0 goes out next
        if (first_q) begin
            nxt_bit  = '0;
            nxt_slot = '0;
        end

        s_ready  = (state == IDLE) ? enable : (enable && at_last && !first_q);
        load_new = (state == RUN) && at_last && !first_q && enable;

        emit_frame = frame_q;
        emit_fmt   = fmt_q;
        if (load_new) begin
            emit_frame = s_valid ? s_data : '0;
            emit_fmt   = s_valid ? fmt_i2s : fmt_q;
        end
        lj_nxt = slot_bit(emit_frame, int'(nxt_slot), int'(nxt_bit));
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            slot_cnt    <= '0;
            frame_q     <= '0;
            fmt_q       <= 1'b0;
            first_q     <= 1'b0;
            dly_q       <= 1'b0;
            lrclk       <= 1'b0;
            sd          <= 1'b0;
            slot_idx    <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    lrclk       <= 1'b0;
                    slot_idx    <= '0;
                    frame_start <= 1'b0;
                    sd          <= fmt_q & dly_q;
                    dly_q       <= 1'b0;
                    bit_cnt     <= '0;
                    slot_cnt    <= '0;
                    if (s_valid && s_ready) begin
                        frame_q <= s_data;
                        fmt_q   <= fmt_i2s;
                        first_q <= 1'b1;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (at_last && !first_q && !enable) begin
                        // I2S still owes the delayed LSB on this edge
                        state       <= IDLE;
                        busy        <= 1'b0;
                        lrclk       <= 1'b0;
                        slot_idx    <= '0;
                        frame_start <= 1'b0;
                        sd          <= fmt_q & dly_q;
                        dly_q       <= 1'b0;
                        bit_cnt     <= '0;
                        slot_cnt    <= '0;
                    end else begin
                        if (load_new) begin
                            frame_q <= emit_frame;
                            fmt_q   <= emit_fmt;
                            if (!s_valid) underrun <= 1'b1;
                        end
                        first_q     <= 1'b0;
                        bit_cnt     <= nxt_bit;
                        slot_cnt    <= nxt_slot;
                        slot_idx    <= nxt_slot;
                        lrclk       <= (nxt_slot >= SLOT_HALF);
                        frame_start <= (nxt_bit == '0) && (nxt_slot == '0);
                        sd          <= emit_fmt ? dly_q : lj_nxt;
                        dly_q       <= lj_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Randomised bench for i2s_frame_tx: two configurations checked every cycle
// against a frame-level bit-stream model, plus directed word captures.
module tb_i2s_frame_tx;

    logic bclk = 1'b0;
    always #5 bclk = ~bclk;

    logic        rst, enable, fmt_i2s, valid;
    logic [31:0] da;
    logic [63:0] db;

    logic       rdy_a, lr_a, sd_a, fs_a, ur_a, busy_a;
    logic [0:0] si_a;
    logic       rdy_b, lr_b, sd_b, fs_b, ur_b, busy_b;
    logic [1:0] si_b;

    i2s_frame_tx dut_a (
        .bclk(bclk), .rst(rst), .enable(enable), .fmt_i2s(fmt_i2s),
        .s_data(da), .s_valid(valid), .s_ready(rdy_a), .lrclk(lr_a),
        .sd(sd_a), .slot_idx(si_a), .frame_start(fs_a), .underrun(ur_a),
        .busy(busy_a)
    );

    i2s_frame_tx #(.SAMPLE_W(16), .SLOT_W(24), .NUM_CH(4)) dut_b (
        .bclk(bclk), .rst(rst), .enable(enable), .fmt_i2s(fmt_i2s),
        .s_data(db), .s_valid(valid), .s_ready(rdy_b), .lrclk(lr_b),
        .sd(sd_b), .slot_idx(si_b), .frame_start(fs_b), .underrun(ur_b),
        .busy(busy_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each frame is a flat array of left-justified bits.
    int c_samp[2] = '{16, 16};
    int c_slot[2] = '{16, 24};
    int c_nch[2]  = '{2, 4};

    bit m_busy[2], m_first[2], m_fmt[2], m_prev[2], m_under[2];
    int m_pos[2];
    bit m_bits[2][96];
    bit e_lr[2], e_sd[2], e_fs[2];
    int e_slot[2];

    function automatic void load(int k, logic [63:0] d);
        logic [63:0] sh;
        for (int p = 0; p < 96; p++) m_bits[k][p] = 1'b0;
        for (int ch = 0; ch < c_nch[k]; ch++)
            for (int b = 0; b < c_samp[k]; b++) begin
                sh = d >> (ch * c_samp[k] + c_samp[k] - 1 - b);
                m_bits[k][ch * c_slot[k] + b] = sh[0];
            end
    endfunction

    function automatic bit exp_ready(int k);
        int f = c_nch[k] * c_slot[k];
        if (m_busy[k]) return enable && !m_first[k] && (m_pos[k] == f - 1);
        return enable;
    endfunction

    function automatic void emit(int k);
        int s = m_pos[k] / c_slot[k];
        bit lj = m_bits[k][m_pos[k]];
        e_slot[k] = s;
        e_lr[k]   = (s >= c_nch[k] / 2);
        e_fs[k]   = (m_pos[k] == 0);
        e_sd[k]   = m_fmt[k] ? m_prev[k] : lj;
        m_prev[k] = lj;
    endfunction

    function automatic void quiet(int k);
        e_lr[k]   = 1'b0;
        e_fs[k]   = 1'b0;
        e_slot[k] = 0;
        e_sd[k]   = m_fmt[k] & m_prev[k];
        m_prev[k] = 1'b0;
    endfunction

    function automatic void step(int k, logic [63:0] d);
        int f = c_nch[k] * c_slot[k];
        if (rst) begin
            m_busy[k] = 0; m_first[k] = 0; m_fmt[k] = 0; m_prev[k] = 0;
            m_under[k] = 0; m_pos[k] = 0;
            e_lr[k] = 0; e_sd[k] = 0; e_fs[k] = 0; e_slot[k] = 0;
            return;
        end
        if (!m_busy[k]) begin
            quiet(k);
            if (enable && valid) begin
                load(k, d);
                m_fmt[k] = fmt_i2s; m_busy[k] = 1; m_first[k] = 1;
            end
        end else if (m_first[k]) begin
            m_first[k] = 0; m_pos[k] = 0; emit(k);
        end else if (m_pos[k] == f - 1) begin
            if (!enable) begin
                m_busy[k] = 0; quiet(k); m_pos[k] = 0;
            end else begin
                if (valid) begin
                    load(k, d); m_fmt[k] = fmt_i2s;
                end else begin
                    load(k, 64'h0); m_under[k] = 1;
                end
                m_pos[k] = 0; emit(k);
            end
        end else begin
            m_pos[k]++; emit(k);
        end
    endfunction

    logic obs_sd_a, obs_fs_a, obs_ur_a;

    task automatic cycle();
        logic [9:0] got, exp;
        @(negedge bclk);
        got = {rdy_a, busy_a, ur_a, fs_a, lr_a, sd_a, 4'(si_a)};
        exp = {exp_ready(0), m_busy[0], m_under[0], e_fs[0], e_lr[0], e_sd[0], 4'(e_slot[0])};
        check("cfgA rdy/busy/ur/fs/lr/sd/slot", 64'(got), 64'(exp));
        got = {rdy_b, busy_b, ur_b, fs_b, lr_b, sd_b, 4'(si_b)};
        exp = {exp_ready(1), m_busy[1], m_under[1], e_fs[1], e_lr[1], e_sd[1], 4'(e_slot[1])};
        check("cfgB rdy/busy/ur/fs/lr/sd/slot", 64'(got), 64'(exp));
        obs_sd_a = sd_a;
        obs_fs_a = fs_a;
        obs_ur_a = ur_a;
        step(0, {32'h0, da});
        step(1, db);
        @(posedge bclk);
        #1;
    endtask

    task automatic wait_fs(input string tag);
        int t = 0;
        do begin
            cycle();
            t++;
        end while (!obs_fs_a && t < 200);
        check(tag, 64'(obs_fs_a), 64'd1);
    endtask

    logic [31:0] word;

    initial begin
        rst = 1'b1; enable = 1'b0; fmt_i2s = 1'b0; valid = 1'b0;
        da = '0; db = '0;
        @(posedge bclk);
        #1;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (3) cycle();

        // Left-justified, constant data held valid
        enable = 1'b1; valid = 1'b1;
        da = 32'hA5F0_1234;
        db = 64'hFFFF_7FFF_0002_8001;
        wait_fs("lj frame_start seen");
        word = {31'b0, obs_sd_a};
        for (int i = 1; i < 32; i++) begin
            cycle();
            word = {word[30:0], obs_sd_a};
        end
        check("lj serial word", 64'(word), 64'h1234A5F0);
        repeat (100) cycle();

        // I2S: the word is shifted one bclk later
        fmt_i2s = 1'b1;
        wait_fs("i2s frame_start 1");
        wait_fs("i2s frame_start 2");
        word = '0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            word = {word[30:0], obs_sd_a};
        end
        check("i2s serial word", 64'(word), 64'h1234A5F0);
        repeat (60) cycle();

        // Underrun across at least one boundary, then data returns
        fmt_i2s = 1'b0;
        valid = 1'b0;
        repeat (40) cycle();
        valid = 1'b1;
        repeat (200) cycle();
        check("underrun sticky", 64'(obs_ur_a), 64'd1);

        // enable dropped mid-frame, then re-enabled
        repeat (7) cycle();
        enable = 1'b0;
        repeat (150) cycle();
        enable = 1'b1;
        repeat (60) cycle();

        // Reset mid-frame with valid data present
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("underrun cleared by rst", 64'(obs_ur_a), 64'd0);
        repeat (50) cycle();

        // Randomised traffic
        repeat (4000) begin
            rst     = ($urandom_range(0, 399) == 0);
            enable  = ($urandom_range(0, 19) != 0);
            valid   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) fmt_i2s = ~fmt_i2s;
            da = $urandom;
            db = {$urandom, $urandom};
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
